// File: rtl/controle_multiciclo_if.sv
// Opcode in, datapath strobes and status out, for the multi-cycle control unit.
// master = control unit side, slave = datapath/observer side.
interface controle_multiciclo_if #(
  parameter int CNT_WIDTH = 16
);
  logic [5:0]           opcode;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 mem_to_reg;
  logic                 ir_write;
  logic                 reg_dst;
  logic                 reg_write;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic [1:0]           pc_source;
  logic [3:0]           estado;
  logic                 opcode_invalido;
  logic [CNT_WIDTH-1:0] instr_count;

  modport master (
    input  opcode,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, estado, opcode_invalido, instr_count
  );

  modport slave (
    output opcode,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, estado, opcode_invalido, instr_count
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Moore control FSM for the multi-cycle MIPS datapath; 3-5 cycles per instruction, no backpressure.
// Strobes are registered alongside the state and forced low while reset is held.
module controle_multiciclo #(
  parameter logic [5:0]  OP_RTYPE  = 6'd0,
  parameter logic [5:0]  OP_LW     = 6'd35,
  parameter logic [5:0]  OP_SW     = 6'd43,
  parameter logic [5:0]  OP_BEQ    = 6'd4,
  parameter logic [5:0]  OP_J      = 6'd2,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  controle_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    LW_WB     = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9
  } estado_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  function automatic ctl_t decode(input estado_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      DECODE:    c.alu_src_b = 2'b11;
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      LW_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Unknown opcodes in DECODE fall back to FETCH without retiring anything.
  function automatic estado_t proximo(input estado_t s, input logic [5:0] op);
    estado_t n;
    n = FETCH;
    case (s)
      FETCH: n = DECODE;
      DECODE: begin
        if (op == OP_LW || op == OP_SW) n = MEM_ADDR;
        else if (op == OP_RTYPE)        n = EXECUTE;
        else if (op == OP_BEQ)          n = BRANCH;
        else if (op == OP_J)            n = JUMP;
        else                            n = FETCH;
      end
      MEM_ADDR: n = (op == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ: n = LW_WB;
      EXECUTE:  n = R_WB;
      default:  n = FETCH;
    endcase
    return n;
  endfunction

  estado_t              estado_q;
  estado_t              estado_d;
  ctl_t                 ctl_q;
  ctl_t                 ctl_o;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 op_valido;

  assign estado_d  = proximo(estado_q, bus.opcode);
  assign op_valido = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW) ||
                     (bus.opcode == OP_SW) || (bus.opcode == OP_BEQ) ||
                     (bus.opcode == OP_J);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= FETCH;
      ctl_q    <= decode(FETCH);
      count_q  <= '0;
    end else begin
      estado_q <= estado_d;
      ctl_q    <= decode(estado_d);
      if (estado_q inside {LW_WB, MEM_WRITE, R_WB, BRANCH, JUMP})
        count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  // Reset silences the datapath immediately, even before the clock edge lands.
  assign ctl_o = reset ? '0 : ctl_q;

  assign bus.pc_write        = ctl_o.pc_write;
  assign bus.pc_write_cond   = ctl_o.pc_write_cond;
  assign bus.i_or_d          = ctl_o.i_or_d;
  assign bus.mem_read        = ctl_o.mem_read;
  assign bus.mem_write       = ctl_o.mem_write;
  assign bus.mem_to_reg      = ctl_o.mem_to_reg;
  assign bus.ir_write        = ctl_o.ir_write;
  assign bus.reg_dst         = ctl_o.reg_dst;
  assign bus.reg_write       = ctl_o.reg_write;
  assign bus.alu_src_a       = ctl_o.alu_src_a;
  assign bus.alu_src_b       = ctl_o.alu_src_b;
  assign bus.alu_op          = ctl_o.alu_op;
  assign bus.pc_source       = ctl_o.pc_source;
  assign bus.estado          = reset ? 4'd0 : estado_q;
  assign bus.opcode_invalido = !reset && (estado_q == DECODE) && !op_valido;
  assign bus.instr_count     = count_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: a 16-bit and a 4-bit counter instance share stimulus
// and are compared each cycle against a per-instruction state-sequence model.
module tb_controle_multiciclo;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  int         checks;
  int         errors;
  logic [31:0] exp_cnt;

  controle_multiciclo_if #(.CNT_WIDTH(16)) ifa ();
  controle_multiciclo_if #(.CNT_WIDTH(4))  ifb ();

  controle_multiciclo #(.CNT_WIDTH(16)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
  controle_multiciclo #(.CNT_WIDTH(4))  dut_b (.clock(clock), .reset(reset), .bus(ifb));

  assign ifa.opcode = opcode;
  assign ifb.opcode = opcode;

  logic [15:0] ctl_a;
  logic [15:0] ctl_b;
  assign ctl_a = {ifa.pc_write, ifa.pc_write_cond, ifa.i_or_d, ifa.mem_read, ifa.mem_write,
                  ifa.mem_to_reg, ifa.ir_write, ifa.reg_dst, ifa.reg_write, ifa.alu_src_a,
                  ifa.alu_src_b, ifa.alu_op, ifa.pc_source};
  assign ctl_b = {ifb.pc_write, ifb.pc_write_cond, ifb.i_or_d, ifb.mem_read, ifb.mem_write,
                  ifb.mem_to_reg, ifb.ir_write, ifb.reg_dst, ifb.reg_write, ifb.alu_src_a,
                  ifb.alu_src_b, ifb.alu_op, ifb.pc_source};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe word expected in each state, straight from the state table.
  function automatic logic [15:0] exp_ctl(input int s);
    logic pw, pwc, iod, mr, mw, m2r, irw, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mr, mw, m2r, irw, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0: begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
      1: asb = 2'b11;
      2: begin asa = 1; asb = 2'b10; end
      3: begin mr = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; iod = 1; end
      6: begin asa = 1; aop = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9: begin pw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, m2r, irw, rd, rw, asa, asb, aop, psrc};
  endfunction

  // Runs one instruction (or its first 'stop' states); called and returns just after a rising edge.
  task automatic run_instr(input logic [5:0] op, input int stop);
    int  seq[$];
    bit  valid;
    int  n;
    int  s;
    valid = 1'b1;
    case (op)
      6'd35:   seq = '{0, 1, 2, 3, 4};
      6'd43:   seq = '{0, 1, 2, 5};
      6'd0:    seq = '{0, 1, 6, 7};
      6'd4:    seq = '{0, 1, 8};
      6'd2:    seq = '{0, 1, 9};
      default: begin seq = '{0, 1}; valid = 1'b0; end
    endcase
    opcode = op;
    n = (stop > 0 && stop < seq.size()) ? stop : seq.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      s = seq[k];
      check("estado_a", {28'd0, ifa.estado}, s);
      check("estado_b", {28'd0, ifb.estado}, s);
      check("ctl_a", {16'd0, ctl_a}, {16'd0, exp_ctl(s)});
      check("ctl_b", {16'd0, ctl_b}, {16'd0, exp_ctl(s)});
      check("inval_a", {31'd0, ifa.opcode_invalido}, {31'd0, (s == 1 && !valid)});
      check("inval_b", {31'd0, ifb.opcode_invalido}, {31'd0, (s == 1 && !valid)});
      check("cnt_a", {16'd0, ifa.instr_count}, {16'd0, exp_cnt[15:0]});
      check("cnt_b", {28'd0, ifb.instr_count}, {28'd0, exp_cnt[3:0]});
      @(posedge clock);
      #1;
      if (k == seq.size() - 1 && valid) exp_cnt = exp_cnt + 1;
    end
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      check("rst_estado", {28'd0, ifa.estado}, 32'd0);
      check("rst_ctl_a", {16'd0, ctl_a}, 32'd0);
      check("rst_ctl_b", {16'd0, ctl_b}, 32'd0);
      check("rst_inval", {31'd0, ifa.opcode_invalido}, 32'd0);
      if (i > 0) check("rst_cnt", {16'd0, ifa.instr_count}, 32'd0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  always @(negedge clock) begin
    check("excl_pc", {31'd0, ifa.pc_write & ifa.pc_write_cond}, 32'd0);
    check("excl_mem", {31'd0, ifa.mem_read & ifa.mem_write}, 32'd0);
    check("aluop_ne3", {31'd0, (ifa.alu_op == 2'b11)}, 32'd0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    int         r;
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    reset   = 1'b1;
    opcode  = 6'd0;

    do_reset(2);
    run_instr(6'd35, 0);
    run_instr(6'd43, 0);
    run_instr(6'd0, 0);
    run_instr(6'd4, 0);
    run_instr(6'd2, 0);
    run_instr(6'd63, 0);
    check("cnt_after_inval", {16'd0, ifa.instr_count}, 32'd5);

    // Reset lands while the lw sits in MEM_READ.
    run_instr(6'd35, 3);
    do_reset(2);
    run_instr(6'd35, 0);
    run_instr(6'd43, 0);

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: op = 6'd35;
        1: op = 6'd43;
        2: op = 6'd0;
        3: op = 6'd4;
        4: op = 6'd2;
        default: op = 6'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 7) == 0) begin
        run_instr(op, $urandom_range(1, 4));
        do_reset($urandom_range(1, 2));
      end else begin
        run_instr(op, 0);
      end
    end

    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      run_instr(6'd2, 0);
      check("wrap_b", {28'd0, ifb.instr_count}, (i + 1) % 16);
    end
    check("wrap_a", {16'd0, ifa.instr_count}, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
